serial_pattern_tx: RTL and testbench

- Parallel-to-serial bit-stream transmitter. Drives the single-bit serial line `w` consumed by the team's serial sequence detectors.
- Accepts a word of 1..WIDTH bits through a valid/ready handshake and emits it MSB-first, holding each bit for BIT_CYCLES clocks.
- Optionally appends a low inter-word gap, then pulses done.
- Used as the stimulus/pattern source in front of detector FSMs on the lab board and in benches.

---
 rtl/serial_pattern_tx_pkg.sv | 16 +
 rtl/serial_pattern_tx_bit_period_timer.sv | 28 ++
 rtl/serial_pattern_tx.sv | 123 ++++++++++++
 tb/tb_serial_pattern_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package serial_pkg;

    // Transmitter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Requested word lengths above the shift register size are sent as full words.
    function automatic int clamp_len(input int len, input int width);
        return (len > width) ? width : len;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_bit_period_timer.sv
// Bit-period down-counter: ticks on the last clock of every BIT_CYCLES-long period.
module bit_period_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int PW = $clog2(BIT_CYCLES + 1);

    logic [PW-1:0] cnt;

    assign tick = (cnt == '0);

    // Restart the period on load, reload at the end of each period, otherwise count down.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= PW'(BIT_CYCLES - 1);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial pattern source: sends 1..WIDTH bits MSB-first on w,
// each held BIT_CYCLES clocks, followed by an optional low gap and a done pulse.
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_BITS   = 0,
    parameter int LENW       = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LENW-1:0]  len_in,
    input  logic             valid,
    output logic             ready,
    output logic             w,
    output logic             busy,
    output logic             done
);

    localparam int GAP_CYC = GAP_BITS * BIT_CYCLES;
    localparam int GAPW    = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] data_aligned;
    logic [LENW-1:0]  bit_cnt;
    logic [LENW-1:0]  len_c;
    logic [GAPW-1:0]  gap_cnt;
    logic             accept;
    logic             tick;

    assign ready        = (state == IDLE);
    assign accept       = valid && ready;
    assign len_c        = LENW'(clamp_len(int'(len_in), WIDTH));
    // Left-justify the word so the first bit to send always sits at the MSB.
    assign data_aligned = data_in << (WIDTH - int'(len_c));
    assign sr_next      = sr << 1;

    bit_period_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk  (Clk),
        .rst  (Rst),
        .load (accept),
        .tick (tick)
    );

    // Transmit FSM with registered w/busy/done; bit_cnt holds bits still to finish.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            w       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sr      <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    w    <= 1'b0;
                    busy <= 1'b0;
                    if (accept) begin
                        if (len_c != '0) begin
                            state   <= SHIFT;
                            sr      <= data_aligned;
                            bit_cnt <= len_c;
                            w       <= data_aligned[WIDTH-1];
                            busy    <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_cnt == '0) begin
                        state <= IDLE;
                        w     <= 1'b0;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        if (bit_cnt == LENW'(1)) begin
                            w <= 1'b0;
                            if (GAP_BITS > 0) begin
                                state   <= GAP;
                                gap_cnt <= GAPW'(GAP_BITS - 1);
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            sr      <= sr_next;
                            w       <= sr_next[WIDTH-1];
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                GAP: begin
                    w <= 1'b0;
                    if (tick) begin
                        if (gap_cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    w     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: three instances cover
// (BIT_CYCLES=1,GAP=0), (BIT_CYCLES=3,GAP=0) and (BIT_CYCLES=1,GAP=2).
module tb_serial_pattern_tx;

    logic            Clk;
    logic            Rst;
    logic [2:0][7:0] din;
    logic [2:0][3:0] len;
    logic [2:0]      vld;
    logic [2:0]      rdy_o;
    logic [2:0]      w_o;
    logic [2:0]      busy_o;
    logic [2:0]      done_o;

    int vectors;
    int miscompares;

    serial_pattern_tx #(.WIDTH(8), .BIT_CYCLES(1), .GAP_BITS(0)) u0 (
        .Clk(Clk), .Rst(Rst), .data_in(din[0]), .len_in(len[0]), .valid(vld[0]),
        .ready(rdy_o[0]), .w(w_o[0]), .busy(busy_o[0]), .done(done_o[0]));

    serial_pattern_tx #(.WIDTH(8), .BIT_CYCLES(3), .GAP_BITS(0)) u1 (
        .Clk(Clk), .Rst(Rst), .data_in(din[1]), .len_in(len[1]), .valid(vld[1]),
        .ready(rdy_o[1]), .w(w_o[1]), .busy(busy_o[1]), .done(done_o[1]));

    serial_pattern_tx #(.WIDTH(8), .BIT_CYCLES(1), .GAP_BITS(2)) u2 (
        .Clk(Clk), .Rst(Rst), .data_in(din[2]), .len_in(len[2]), .valid(vld[2]),
        .ready(rdy_o[2]), .w(w_o[2]), .busy(busy_o[2]), .done(done_o[2]));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs of instance k: w, busy, done, ready.
    task automatic chk_out(input string tag, input int k,
                           input logic ew, input logic eb, input logic ed, input logic er);
        chk({tag, ".w"},     {31'd0, w_o[k]},    {31'd0, ew});
        chk({tag, ".busy"},  {31'd0, busy_o[k]}, {31'd0, eb});
        chk({tag, ".done"},  {31'd0, done_o[k]}, {31'd0, ed});
        chk({tag, ".ready"}, {31'd0, rdy_o[k]},  {31'd0, er});
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        vectors     = 0;
        miscompares = 0;
        Rst = 1'b1;
        din = '0;
        len = '0;
        vld = '0;

        // Reset held two cycles, then idle outputs.
        step();
        step();
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("idle%0d.u0", i), 0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk_out($sformatf("idle%0d.u2", i), 2, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end

        // 8'h09, len 4 on BIT_CYCLES=1: w = 1,0,0,1 then done with w=0.
        din[0] = 8'h09; len[0] = 4'd4; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0; din[0] = 8'hFF;
        pat = 8'b1001_0000;
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("w09.b%0d", i), 0, pat[7-i], 1'b1, 1'b0, 1'b0);
            step();
        end
        chk_out("w09.done", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_out("w09.after", 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 8'hF0, len 8, BIT_CYCLES=3: 12 ones, 12 zeros, done 25 cycles after accept.
        din[1] = 8'hF0; len[1] = 4'd8; vld[1] = 1'b1;
        step();
        vld[1] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            chk_out($sformatf("wF0.c%0d", i), 1, (i < 12), 1'b1, 1'b0, 1'b0);
            step();
        end
        chk_out("wF0.done", 1, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_out("wF0.after", 1, 1'b0, 1'b0, 1'b0, 1'b1);

        // GAP_BITS=2, valid held high: 1,1,1,0,0, done, second word accepted in done cycle.
        din[2] = 8'h07; len[2] = 4'd3; vld[2] = 1'b1;
        step();
        din[2] = 8'h02; len[2] = 4'd2;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("gap.b%0d", i), 2, 1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            chk_out($sformatf("gap.g%0d", i), 2, 1'b0, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk_out("gap.done", 2, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        vld[2] = 1'b0;
        chk_out("gap.w2b1", 2, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("gap.w2b0", 2, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("gap.w2g0", 2, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("gap.w2g1", 2, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("gap.w2done", 2, 1'b0, 1'b0, 1'b1, 1'b1);
        step();

        // len 0: done the next cycle, w stays low.
        din[0] = 8'hFF; len[0] = 4'd0; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        chk_out("len0.done", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_out("len0.after", 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // len 12 clamps to 8: 8'hA5 sent whole, done after 8 bits.
        din[0] = 8'hA5; len[0] = 4'd12; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        pat = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            chk_out($sformatf("len12.b%0d", i), 0, pat[7-i], 1'b1, 1'b0, 1'b0);
            step();
        end
        chk_out("len12.done", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();

        // Reset during the 3rd bit of a len 8 word aborts it without done.
        din[0] = 8'hFF; len[0] = 4'd8; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        chk_out("abort.b0", 0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("abort.b1", 0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("abort.b2", 0, 1'b1, 1'b1, 1'b0, 1'b0);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk_out("abort.rst", 0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk_out($sformatf("abort.quiet%0d", i), 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // New word after the abort: 8'h02, len 2 -> w = 1,0 then done.
        din[0] = 8'h02; len[0] = 4'd2; vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        chk_out("post.b1", 0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("post.b0", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("post.done", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
